// File: rtl/cursor_input_ctrl_if.sv
// Cursor controller bus: board-side inputs and renderer-side outputs.
interface cursor_input_ctrl_if #(
   parameter int X_W     = 10,
   parameter int Y_W     = 9,
   parameter int COLOR_W = 4,
   parameter int SW_W    = 3
);
   logic               nf_in;
   logic [3:0]         pos_con_in;
   logic               col_con_in;
   logic               sw_con_in;
   logic [1:0]         rot_a_in;
   logic [1:0]         rot_b_in;
   logic [1:0]         rot_but_in;
   logic [X_W-1:0]     cursor_loc_x;
   logic [Y_W-1:0]     cursor_loc_y;
   logic [COLOR_W-1:0] cursor_color;
   logic [SW_W-1:0]    stroke_width;
   logic               cursor_moved;
   logic [1:0]         quad_err;

   modport master (
      output nf_in, pos_con_in, col_con_in, sw_con_in, rot_a_in, rot_b_in, rot_but_in,
      input  cursor_loc_x, cursor_loc_y, cursor_color, stroke_width, cursor_moved, quad_err
   );

   modport slave (
      input  nf_in, pos_con_in, col_con_in, sw_con_in, rot_a_in, rot_b_in, rot_but_in,
      output cursor_loc_x, cursor_loc_y, cursor_color, stroke_width, cursor_moved, quad_err
   );
endinterface

// File: rtl/cursor_input_ctrl.sv
// Cursor/attribute input controller: two quadrature encoders with push-button
// mode select, d-pad on frame pulses, colour/stroke cycle buttons.
module cursor_input_ctrl #(
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 360,
   parameter int X_W          = 10,
   parameter int Y_W          = 9,
   parameter int COLOR_W      = 4,
   parameter int SW_W         = 3,
   parameter int MOVE_AMT     = 1,
   parameter int DETENT_TICKS = 4,
   parameter int ACCEL_WINDOW = 250000,
   parameter int ACCEL_STEP   = 4,
   parameter int DEB_CYCLES   = 500000
) (
   input logic clk_in,
   input logic rst_in,
   cursor_input_ctrl_if.slave bus
);
   localparam int ACC_W = $clog2(DETENT_TICKS) + 2;
   localparam int ACW   = $clog2(ACCEL_WINDOW + 1);
   localparam int DBW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam int XS    = X_W + 2;
   localparam int YS    = Y_W + 2;

   localparam logic signed [ACC_W-1:0] ACC_POS = ACC_W'(DETENT_TICKS - 1);
   localparam logic signed [ACC_W-1:0] ACC_NEG = ACC_W'(-(DETENT_TICKS - 1));
   localparam logic [ACW-1:0]          TMR_SAT = ACW'(ACCEL_WINDOW);
   localparam logic [DBW-1:0]          DEB_TOP = DBW'(DEB_CYCLES - 1);
   localparam logic signed [XS-1:0]    X_MAX   = XS'(SCREEN_W - 1);
   localparam logic signed [YS-1:0]    Y_MAX   = YS'(SCREEN_H - 1);
   localparam logic signed [XS-1:0]    X_ACC   = XS'(ACCEL_STEP);
   localparam logic signed [YS-1:0]    Y_ACC   = YS'(ACCEL_STEP);
   localparam logic signed [XS-1:0]    X_ONE   = XS'(1);
   localparam logic signed [YS-1:0]    Y_ONE   = YS'(1);
   localparam logic signed [XS-1:0]    X_MOV   = XS'(MOVE_AMT);
   localparam logic signed [YS-1:0]    Y_MOV   = YS'(MOVE_AMT);
   localparam logic [X_W-1:0]          X_RST   = X_W'(SCREEN_W / 2);
   localparam logic [Y_W-1:0]          Y_RST   = Y_W'(SCREEN_H / 2);
   localparam logic [COLOR_W-1:0]      COL_MAX = '1;
   localparam logic [SW_W-1:0]         SW_MAX  = '1;

   logic [1:0] a_s1, a_s2, b_s1, b_s2, but_s1, but_s2;
   logic [1:0] step_cw, step_ccw, fast, deb, err_vec;

   logic [X_W-1:0]     x_q, x_next;
   logic [Y_W-1:0]     y_q, y_next;
   logic [COLOR_W-1:0] col_q, col_next;
   logic [SW_W-1:0]    sw_q, sw_next;
   logic               moved_q, col_prev, sw_prev;

   logic signed [XS-1:0] enc_dx, pad_dx, x_sum;
   logic signed [YS-1:0] enc_dy, pad_dy, y_sum;

   // Two-stage synchronisers; reset preloads pin values so no phantom edge follows reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         a_s1   <= bus.rot_a_in;   a_s2   <= bus.rot_a_in;
         b_s1   <= bus.rot_b_in;   b_s2   <= bus.rot_b_in;
         but_s1 <= bus.rot_but_in; but_s2 <= bus.rot_but_in;
      end else begin
         a_s1   <= bus.rot_a_in;   a_s2   <= a_s1;
         b_s1   <= bus.rot_b_in;   b_s2   <= b_s1;
         but_s1 <= bus.rot_but_in; but_s2 <= but_s1;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_enc
      logic [1:0]              prev_q, cur;
      logic                    cw, ccw, bad, err_q, last_dir, deb_q;
      logic signed [ACC_W-1:0] acc;
      logic [ACW-1:0]          tmr;
      logic [DBW-1:0]          deb_cnt;

      assign cur = {a_s2[i], b_s2[i]};

      // Classify the {A,B} transition since last cycle.
      always_comb begin
         cw  = 1'b0;
         ccw = 1'b0;
         case ({prev_q, cur})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: cw  = 1'b1;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: ccw = 1'b1;
            default: ;
         endcase
         bad = ((prev_q ^ cur) == 2'b11);
      end

      assign step_cw[i]  = cw  && (acc == ACC_POS);
      assign step_ccw[i] = ccw && (acc == ACC_NEG);
      assign fast[i]     = (tmr < TMR_SAT) && (last_dir == step_cw[i]);
      assign deb[i]      = deb_q;
      assign err_vec[i]  = err_q;

      // Detent accumulator and sticky illegal-transition flag; illegal jumps leave the count alone.
      always_ff @(posedge clk_in) begin
         if (rst_in) begin
            prev_q <= {bus.rot_a_in[i], bus.rot_b_in[i]};
            acc    <= '0;
            err_q  <= 1'b0;
         end else begin
            prev_q <= cur;
            if (bad)
               err_q <= 1'b1;
            else if (step_cw[i] || step_ccw[i])
               acc <= '0;
            else if (cw)
               acc <= acc + ACC_W'(1);
            else if (ccw)
               acc <= acc - ACC_W'(1);
         end
      end

      // Cycles since the last step, saturating; restarts on every emitted step.
      always_ff @(posedge clk_in) begin
         if (rst_in) begin
            tmr      <= TMR_SAT;
            last_dir <= 1'b0;
         end else if (step_cw[i] || step_ccw[i]) begin
            tmr      <= '0;
            last_dir <= step_cw[i];
         end else if (tmr != TMR_SAT) begin
            tmr <= tmr + ACW'(1);
         end
      end

      // Push-button debounce: down-counter runs while the input differs from the held level.
      always_ff @(posedge clk_in) begin
         if (rst_in) begin
            deb_q   <= 1'b0;
            deb_cnt <= DEB_TOP;
         end else if (but_s2[i] == deb_q) begin
            deb_cnt <= DEB_TOP;
         end else if (deb_cnt == '0) begin
            deb_q   <= but_s2[i];
            deb_cnt <= DEB_TOP;
         end else begin
            deb_cnt <= deb_cnt - DBW'(1);
         end
      end
   end

   // Sum encoder and d-pad deltas per axis, then clamp once into the canvas.
   always_comb begin
      enc_dx = '0;
      enc_dy = '0;
      pad_dx = '0;
      pad_dy = '0;
      if (deb[0] && step_cw[0])  enc_dx = fast[0] ? X_ACC : X_ONE;
      if (deb[0] && step_ccw[0]) enc_dx = fast[0] ? -X_ACC : -X_ONE;
      if (deb[1] && step_cw[1])  enc_dy = fast[1] ? Y_ACC : Y_ONE;
      if (deb[1] && step_ccw[1]) enc_dy = fast[1] ? -Y_ACC : -Y_ONE;
      if (bus.nf_in) begin
         if (bus.pos_con_in[2]) pad_dx = pad_dx + X_MOV;
         if (bus.pos_con_in[3]) pad_dx = pad_dx - X_MOV;
         if (bus.pos_con_in[1]) pad_dy = pad_dy + Y_MOV;
         if (bus.pos_con_in[0]) pad_dy = pad_dy - Y_MOV;
      end
      x_sum = $signed({2'b00, x_q}) + enc_dx + pad_dx;
      y_sum = $signed({2'b00, y_q}) + enc_dy + pad_dy;
      if (x_sum[XS-1])        x_next = '0;
      else if (x_sum > X_MAX) x_next = X_MAX[X_W-1:0];
      else                    x_next = x_sum[X_W-1:0];
      if (y_sum[YS-1])        y_next = '0;
      else if (y_sum > Y_MAX) y_next = Y_MAX[Y_W-1:0];
      else                    y_next = y_sum[Y_W-1:0];
   end

   // Attribute fields: button edge wraps and overrides a same-cycle encoder step, which saturates.
   always_comb begin
      sw_next  = sw_q;
      col_next = col_q;
      if (bus.sw_con_in && !sw_prev)                     sw_next = sw_q + SW_W'(1);
      else if (!deb[0] && step_cw[0] && sw_q != SW_MAX)  sw_next = sw_q + SW_W'(1);
      else if (!deb[0] && step_ccw[0] && sw_q != '0)     sw_next = sw_q - SW_W'(1);
      if (bus.col_con_in && !col_prev)                      col_next = col_q + COLOR_W'(1);
      else if (!deb[1] && step_cw[1] && col_q != COL_MAX)   col_next = col_q + COLOR_W'(1);
      else if (!deb[1] && step_ccw[1] && col_q != '0)       col_next = col_q - COLOR_W'(1);
   end

   // Output registers and button edge history.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         x_q      <= X_RST;
         y_q      <= Y_RST;
         col_q    <= '0;
         sw_q     <= '0;
         moved_q  <= 1'b0;
         col_prev <= bus.col_con_in;
         sw_prev  <= bus.sw_con_in;
      end else begin
         x_q      <= x_next;
         y_q      <= y_next;
         col_q    <= col_next;
         sw_q     <= sw_next;
         moved_q  <= (x_next != x_q) || (y_next != y_q);
         col_prev <= bus.col_con_in;
         sw_prev  <= bus.sw_con_in;
      end
   end

   assign bus.cursor_loc_x = x_q;
   assign bus.cursor_loc_y = y_q;
   assign bus.cursor_color = col_q;
   assign bus.stroke_width = sw_q;
   assign bus.cursor_moved = moved_q;
   assign bus.quad_err     = err_vec;
endmodule

// File: tb/tb_cursor_input_ctrl.sv
// Scoreboard bench for cursor_input_ctrl: stimulus pushes expectations, monitor compares.
module tb_cursor_input_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cursor_input_ctrl_if #(.X_W(10), .Y_W(9), .COLOR_W(4), .SW_W(3)) bus();

   cursor_input_ctrl #(.DEB_CYCLES(16), .ACCEL_WINDOW(64)) dut (
      .clk_in(clk), .rst_in(rst), .bus(bus)
   );

   typedef struct {
      string name;
      int x; int y; int col; int sw; int err;
   } exp_t;

   exp_t move_q[$];
   exp_t snap_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   bit   snap_req = 1'b0;
   int   cx = 320;
   int   cy = 180;

   // Monitor: compares every moved pulse and every requested snapshot.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.cursor_moved) begin
            n_vec++;
            if (move_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_move: got x=%0d y=%0d, no move expected",
                        bus.cursor_loc_x, bus.cursor_loc_y);
            end else begin
               e = move_q.pop_front();
               if (int'(bus.cursor_loc_x) != e.x || int'(bus.cursor_loc_y) != e.y) begin
                  n_bad++;
                  $display("FAIL %s: got x=%0d y=%0d, expected x=%0d y=%0d",
                           e.name, bus.cursor_loc_x, bus.cursor_loc_y, e.x, e.y);
               end
            end
         end
         if (snap_req) begin
            n_vec++;
            if (snap_q.size() == 0) begin
               n_bad++;
               $display("FAIL snapshot_queue: snapshot requested with no expectation");
            end else begin
               e = snap_q.pop_front();
               if (int'(bus.cursor_loc_x) != e.x || int'(bus.cursor_loc_y) != e.y ||
                   int'(bus.cursor_color) != e.col || int'(bus.stroke_width) != e.sw ||
                   int'(bus.quad_err) != e.err) begin
                  n_bad++;
                  $display("FAIL %s: got x=%0d y=%0d col=%0d sw=%0d err=%0d, expected x=%0d y=%0d col=%0d sw=%0d err=%0d",
                           e.name, bus.cursor_loc_x, bus.cursor_loc_y, bus.cursor_color,
                           bus.stroke_width, bus.quad_err, e.x, e.y, e.col, e.sw, e.err);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap(input string nm, input int x, input int y, input int col,
                       input int sw, input int err);
      exp_t e;
      e.name = nm; e.x = x; e.y = y; e.col = col; e.sw = sw; e.err = err;
      snap_q.push_back(e);
      snap_req = 1'b1;
      tick(1);
      snap_req = 1'b0;
   endtask

   task automatic exp_move(input string nm, input int x, input int y);
      exp_t e;
      e.name = nm; e.x = x; e.y = y; e.col = 0; e.sw = 0; e.err = 0;
      move_q.push_back(e);
      cx = x;
      cy = y;
   endtask

   task automatic turn(input int enc, input bit cw);
      logic [1:0] st, nx;
      st = {bus.rot_a_in[enc], bus.rot_b_in[enc]};
      if (cw) begin
         case (st)
            2'b00: nx = 2'b10;
            2'b10: nx = 2'b11;
            2'b11: nx = 2'b01;
            default: nx = 2'b00;
         endcase
      end else begin
         case (st)
            2'b00: nx = 2'b01;
            2'b01: nx = 2'b11;
            2'b11: nx = 2'b10;
            default: nx = 2'b00;
         endcase
      end
      bus.rot_a_in[enc] = nx[1];
      bus.rot_b_in[enc] = nx[0];
   endtask

   // extra: 0 none, 1 d-pad up pulse on the update edge, 2 colour button edge on the update edge
   task automatic detent(input string nm, input int enc, input bit cw, input int extra,
                         input bit has_move, input int ex, input int ey);
      for (int k = 0; k < 4; k++) begin
         if (k == 3 && has_move) exp_move(nm, ex, ey);
         turn(enc, cw);
         if (k < 3) tick(5);
      end
      if (extra == 1) begin
         tick(2);
         bus.nf_in = 1'b1; bus.pos_con_in = 4'b0001;
         tick(1);
         bus.nf_in = 1'b0; bus.pos_con_in = 4'b0000;
      end else if (extra == 2) begin
         tick(2);
         bus.col_con_in = 1'b1;
         tick(1);
      end
      tick(5);
   endtask

   task automatic pad(input string nm, input logic [3:0] pv, input int n);
      int nx, ny;
      for (int k = 0; k < n; k++) begin
         nx = cx + (pv[2] ? 1 : 0) - (pv[3] ? 1 : 0);
         ny = cy + (pv[1] ? 1 : 0) - (pv[0] ? 1 : 0);
         if (nx < 0) nx = 0;
         if (nx > 639) nx = 639;
         if (ny < 0) ny = 0;
         if (ny > 359) ny = 359;
         if (nx != cx || ny != cy) exp_move(nm, nx, ny);
         bus.pos_con_in = pv; bus.nf_in = 1'b1;
         tick(1);
         bus.nf_in = 1'b0; bus.pos_con_in = 4'b0000;
         tick(1);
      end
   endtask

   task automatic press(input bit col, input int n);
      for (int k = 0; k < n; k++) begin
         if (col) bus.col_con_in = 1'b1; else bus.sw_con_in = 1'b1;
         tick(1);
         bus.col_con_in = 1'b0; bus.sw_con_in = 1'b0;
         tick(1);
      end
   endtask

   initial begin
      bus.nf_in = 1'b0; bus.pos_con_in = 4'b0000;
      bus.col_con_in = 1'b0; bus.sw_con_in = 1'b0;
      bus.rot_a_in = 2'b00; bus.rot_b_in = 2'b00; bus.rot_but_in = 2'b00;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(10);
      snap("reset_state", 320, 180, 0, 0, 0);

      // position mode
      bus.rot_but_in = 2'b11;
      tick(40);
      for (int k = 0; k < 3; k++) begin turn(0, 1'b1); tick(5); end
      exp_move("detent1_x", 321, 180);
      turn(0, 1'b1);
      tick(2);
      snap("latency_two_edges", 320, 180, 0, 0, 0);
      tick(5);
      snap("detent1_settled", 321, 180, 0, 0, 0);
      detent("accel_cw", 0, 1'b1, 0, 1'b1, 325, 180);
      detent("reverse_ccw", 0, 1'b0, 0, 1'b1, 324, 180);
      snap("after_reverse", 324, 180, 0, 0, 0);

      // right edge clamp
      pad("pad_right", 4'b0100, 313);
      detent("x_to_638", 0, 1'b1, 0, 1'b1, 638, 180);
      detent("x_clamp_639", 0, 1'b1, 0, 1'b1, 639, 180);
      snap("right_clamp", 639, 180, 0, 0, 0);

      // top edge: d-pad and encoder summed before clamp
      pad("pad_up", 4'b0001, 179);
      snap("y_at_1", 639, 1, 0, 0, 0);
      detent("y_sum_clamp", 1, 1'b0, 1, 1'b1, 639, 0);
      snap("y_clamped_0", 639, 0, 0, 0, 0);

      // attribute mode
      bus.rot_but_in = 2'b00;
      tick(40);
      press(1'b1, 15);
      snap("colour_15", 639, 0, 15, 0, 0);
      detent("colour_sat", 1, 1'b1, 0, 1'b0, 0, 0);
      snap("colour_saturate", 639, 0, 15, 0, 0);
      press(1'b1, 1);
      snap("colour_wrap", 639, 0, 0, 0, 0);
      press(1'b1, 5);
      detent("button_wins", 1, 1'b0, 2, 1'b0, 0, 0);
      bus.col_con_in = 1'b0;
      tick(2);
      snap("button_beats_encoder", 639, 0, 6, 0, 0);
      detent("stroke_cw", 0, 1'b1, 0, 1'b0, 0, 0);
      snap("stroke_encoder", 639, 0, 6, 1, 0);
      press(1'b0, 1);
      snap("stroke_button", 639, 0, 6, 2, 0);

      // illegal transition keeps the partial count
      turn(0, 1'b1); tick(5);
      turn(0, 1'b1); tick(5);
      bus.rot_a_in[0] = 1'b0; bus.rot_b_in[0] = 1'b0;
      tick(5);
      snap("quad_err_set", 639, 0, 6, 2, 1);
      turn(0, 1'b1); tick(5);
      turn(0, 1'b1); tick(5);
      snap("acc_kept_after_err", 639, 0, 6, 3, 1);

      // reset mid-detent discards partial ticks
      turn(0, 1'b1); tick(5);
      turn(0, 1'b1); tick(5);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      cx = 320; cy = 180;
      tick(5);
      turn(0, 1'b1); tick(5);
      turn(0, 1'b1); tick(5);
      snap("partial_after_reset", 320, 180, 0, 0, 0);
      turn(0, 1'b1); tick(5);
      turn(0, 1'b1); tick(5);
      snap("full_detent_after_reset", 320, 180, 0, 1, 0);

      tick(10);
      n_vec++;
      if (move_q.size() != 0 || snap_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_expectations: got %0d moves and %0d snapshots pending, expected 0 and 0",
                  move_q.size(), snap_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/cursor_input_ctrl.md
Name: cursor_input_ctrl

Overview:
- Parametrised next-generation cursor/attribute input controller for the drawing front end.
- Sits between the board I/O (2 quadrature rotary encoders with push buttons, 4-way d-pad switches, colour/stroke buttons) and the canvas/stroke renderer.
- Adds the following, all parametrised on screen size and attribute widths:
  - full quadrature state decoding with illegal-transition rejection;
  - detent accumulation, velocity acceleration and button debouncing;
  - a defined arbitration between simultaneous sources.

Parameters:
- SCREEN_W, 640, canvas width in pixels; x range 0..SCREEN_W-1
- SCREEN_H, 360, canvas height in pixels; y range 0..SCREEN_H-1
- X_W, 10, cursor x width (must satisfy 2^X_W >= SCREEN_W)
- Y_W, 9, cursor y width (must satisfy 2^Y_W >= SCREEN_H)
- COLOR_W, 4, colour index width
- SW_W, 3, stroke width field width
- MOVE_AMT, 1, d-pad pixels per nf_in pulse
- DETENT_TICKS, 4, valid quadrature transitions per emitted step
- ACCEL_WINDOW, 250000, max cycles between same-direction steps for acceleration
- ACCEL_STEP, 4, pixels per accelerated step
- DEB_CYCLES, 500000, stable cycles required for encoder push-button debounce

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- nf_in  input  1  new-frame pulse, one cycle
- pos_con_in  input  4  d-pad levels: [0] up, [1] down, [2] right, [3] left
- col_con_in  input  1  colour-cycle button, synchronous level
- sw_con_in  input  1  stroke-cycle button, synchronous level
- rot_a_in  input  2  encoder A phase, index 0 = x/stroke, index 1 = y/colour (asynchronous)
- rot_b_in  input  2  encoder B phase, same indexing as rot_a_in (asynchronous)
- rot_but_in  input  2  encoder push buttons, raw/bouncing (asynchronous)
- cursor_loc_x  output  X_W  cursor x
- cursor_loc_y  output  Y_W  cursor y
- cursor_color  output  COLOR_W  colour index
- stroke_width  output  SW_W  stroke width
- cursor_moved  output  1  one-cycle pulse when x or y changed
- quad_err  output  2  sticky per-encoder illegal-transition flag

Behaviour:
- Reset (synchronous, active-high):
  - cursor_loc_x=SCREEN_W/2, cursor_loc_y=SCREEN_H/2;
  - cursor_color=0, stroke_width=0, cursor_moved=0, quad_err=0;
  - detent accumulators=0, accel timers saturated (no acceleration), debounced buttons=0;
  - synchroniser/previous-state registers load the current pin values, so no spurious step occurs after reset.
  - rst_in asserted mid-rotation discards any partial detent count.
- Synchronisers: rot_a_in, rot_b_in and rot_but_in each pass through 2 flip-flops.
- Quadrature decode, per encoder, on state {A,B}:
  - CW transitions: 00->10, 10->11, 11->01, 01->00. CCW is the reverse of each.
  - A change of both bits is illegal: it sets quad_err[i] and leaves the accumulator untouched.
- Detent accumulation:
  - Signed accumulator, CW +1 / CCW -1.
  - Reaching +DETENT_TICKS emits a CW step; reaching -DETENT_TICKS emits a CCW step. Either event clears the accumulator to 0.
- Latency: a pin edge that completes a detent is reflected on the outputs after exactly 3 rising edges (2 synchroniser stages + 1 update).
- Debounce:
  - The debounced button toggles only after the synchronised level has been stable for DEB_CYCLES cycles.
  - Debounced 1 = position mode: encoder 0 drives x, encoder 1 drives y.
  - Debounced 0 = attribute mode: encoder 0 drives stroke_width, encoder 1 drives cursor_color.
- Acceleration (position mode only), per encoder:
  - A cycle counter resets on each step and saturates at ACCEL_WINDOW.
  - Step size = ACCEL_STEP if the step has the same direction as the previous step and the counter < ACCEL_WINDOW; otherwise step size = 1.
- Attribute steps: ±1 per step, saturating at 0 and at the field maximum.
- D-pad:
  - On nf_in only: dx = (right - left)*MOVE_AMT, dy = (down - up)*MOVE_AMT.
  - Opposite directions pressed together give a net 0.
- Position update, per axis:
  - new = clamp(old + encoder delta + d-pad delta, 0, MAX), with MAX = SCREEN_W-1 for x and SCREEN_H-1 for y.
  - Arithmetic uses signed width X_W+2 (Y_W+2) so no intermediate wrap occurs.
  - Both sources in the same cycle sum before the single clamp.
- cursor_moved = 1 in the cycle after a changed x or y is registered.
- Colour/stroke buttons:
  - Rising edge (registered previous level) increments the field with wrap: max->0.
  - If a button edge and an encoder attribute step hit the same field in the same cycle, the button wins and the encoder step is dropped.
- quad_err[i] clears only on reset.

Test Plan:
- Reset then idle 10 cycles -> x=320, y=180, colour=0, stroke=0, moved never 1.
- Position mode (but=2'b11 held > DEB_CYCLES), encoder 0 makes 1 CW detent (4 transitions, 1000 cycles apart) -> x=321 three edges after the 4th pin edge, moved pulses once.
- Two CW detents 100 cycles apart, ACCEL_WINDOW=250000 -> x=320->321->325. Then a CCW detent -> 324 (a direction change disables acceleration).
- x=638 with an accelerated CW step -> x=639. y=1 with nf_in and up, plus encoder CCW in the same cycle -> y=0 (summed, clamped, no wrap).
- Attribute mode, colour=15: encoder CW -> 15 (saturates). Then col_con_in rising edge -> 0 (wrap). Button edge and CCW step in the same cycle with colour=5 -> 6.
- Encoder A,B jump 00->11 -> quad_err[0]=1, accumulator unchanged. rst_in mid-detent (2 ticks in) -> after release, 4 further ticks are needed for one step.
